// File: rtl/tick_generator.sv
// Programmable square-wave generator: 50% duty output with a glitch-free
// half-period update path and a wrapping count of completed periods.
module tick_generator #(
  parameter int HALF_W       = 17,
  parameter int HALF_DEFAULT = 50000,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_valid,
  input  logic [HALF_W-1:0] cfg_half,
  output logic              cfg_ready,
  output logic              signalOut,
  output logic              period_tick,
  output logic              busy,
  output logic [CNT_W-1:0]  period_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  localparam logic [HALF_W-1:0] HALF_RST = HALF_W'(HALF_DEFAULT);
  localparam logic [HALF_W-1:0] HALF_ONE = HALF_W'(1);
  localparam logic [HALF_W-1:0] HALF_ZERO = '0;

  state_t             state_q, state_d;
  logic [HALF_W-1:0]  cnt_q, cnt_d;
  logic [HALF_W-1:0]  act_half_q, act_half_d;
  logic [HALF_W-1:0]  pend_half_q, pend_half_d;
  logic               pend_v_q, pend_v_d;
  logic               signal_out_q, signal_out_d;
  logic               period_tick_q, period_tick_d;
  logic [CNT_W-1:0]   period_count_q, period_count_d;

  logic               cfg_fire;
  logic               apply_pend;
  logic [HALF_W-1:0]  start_half;

  // A phase of H cycles is counted as H-1 down to 0.
  assign cfg_fire   = cfg_valid && !pend_v_q;
  assign start_half = pend_v_q ? pend_half_q : act_half_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    act_half_d     = act_half_q;
    pend_half_d    = pend_half_q;
    pend_v_d       = pend_v_q;
    signal_out_d   = signal_out_q;
    period_tick_d  = 1'b0;
    period_count_d = period_count_q;
    apply_pend     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        signal_out_d = 1'b0;
        if (enable) begin
          state_d      = ST_HIGH;
          signal_out_d = 1'b1;
          cnt_d        = start_half - HALF_ONE;
          apply_pend   = 1'b1;
        end
      end

      ST_HIGH: begin
        if (cnt_q == HALF_ZERO) begin
          state_d      = ST_LOW;
          signal_out_d = 1'b0;
          cnt_d        = act_half_q - HALF_ONE;
        end else begin
          cnt_d = cnt_q - HALF_ONE;
        end
      end

      ST_LOW: begin
        if (cnt_q == HALF_ZERO) begin
          period_tick_d  = 1'b1;
          period_count_d = period_count_q + CNT_W'(1);
          // Only a period boundary may stop the wave, so no period is ever cut short.
          if (enable) begin
            state_d      = ST_HIGH;
            signal_out_d = 1'b1;
            cnt_d        = start_half - HALF_ONE;
            apply_pend   = 1'b1;
          end else begin
            state_d      = ST_IDLE;
            signal_out_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - HALF_ONE;
        end
      end

      default: begin
        state_d      = ST_IDLE;
        signal_out_d = 1'b0;
      end
    endcase

    if (apply_pend && pend_v_q) begin
      act_half_d = pend_half_q;
      pend_v_d   = 1'b0;
    end

    // A capture on an apply edge lands in pend and waits for the next boundary.
    if (cfg_fire) begin
      pend_half_d = (cfg_half == HALF_ZERO) ? HALF_ONE : cfg_half;
      pend_v_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      act_half_q     <= HALF_RST;
      pend_half_q    <= HALF_RST;
      pend_v_q       <= 1'b0;
      signal_out_q   <= 1'b0;
      period_tick_q  <= 1'b0;
      period_count_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      act_half_q     <= act_half_d;
      pend_half_q    <= pend_half_d;
      pend_v_q       <= pend_v_d;
      signal_out_q   <= signal_out_d;
      period_tick_q  <= period_tick_d;
      period_count_q <= period_count_d;
    end
  end

  assign cfg_ready    = ~pend_v_q;
  assign signalOut    = signal_out_q;
  assign period_tick  = period_tick_q;
  assign busy         = (state_q != ST_IDLE);
  assign period_count = period_count_q;

endmodule

// File: tb/tb_tick_generator.sv
// Directed bench for tick_generator: per-cycle vector table plus hand-written
// sequences for counter wrap and mid-period reset.
module tb_tick_generator;

  localparam int HALF_W = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              cfg_valid;
  logic [HALF_W-1:0] cfg_half;
  logic              cfg_ready;
  logic              signalOut;
  logic              period_tick;
  logic              busy;
  logic [CNT_W-1:0]  period_count;

  int checks;
  int errors;

  tick_generator #(
    .HALF_W       (HALF_W),
    .HALF_DEFAULT (4),
    .CNT_W        (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_half     (cfg_half),
    .cfg_ready    (cfg_ready),
    .signalOut    (signalOut),
    .period_tick  (period_tick),
    .busy         (busy),
    .period_count (period_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             en;
    logic             cv;
    logic [HALF_W-1:0] ch;
    logic             sig;
    logic             tick;
    logic             bsy;
    logic             rdy;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic en, input logic cv, input int ch,
                     input logic sig, input logic tick, input logic bsy,
                     input logic rdy, input int cnt);
    vec_t v;
    v.en = en; v.cv = cv; v.ch = HALF_W'(ch);
    v.sig = sig; v.tick = tick; v.bsy = bsy; v.rdy = rdy; v.cnt = CNT_W'(cnt);
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic sig, input logic tick,
                           input logic bsy, input logic rdy, input int cnt);
    check({tag, ".signalOut"}, int'(signalOut), int'(sig));
    check({tag, ".period_tick"}, int'(period_tick), int'(tick));
    check({tag, ".busy"}, int'(busy), int'(bsy));
    check({tag, ".cfg_ready"}, int'(cfg_ready), int'(rdy));
    check({tag, ".period_count"}, int'(period_count), cnt);
  endtask

  initial begin
    int ticks;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    enable    = 1'b1;
    cfg_valid = 1'b0;
    cfg_half  = '0;

    // en cv ch | sig tick busy rdy count
    // Period 1 continuous (4+4), period 2 with enable dropped early.
    add(1,0,0, 1,0,1,1,0); add(1,0,0, 1,0,1,1,0); add(1,0,0, 1,0,1,1,0); add(1,0,0, 1,0,1,1,0);
    add(1,0,0, 0,0,1,1,0); add(1,0,0, 0,0,1,1,0); add(1,0,0, 0,0,1,1,0); add(1,0,0, 0,0,1,1,0);
    add(1,0,0, 1,1,1,1,1); add(1,0,0, 1,0,1,1,1); add(0,0,0, 1,0,1,1,1); add(0,0,0, 1,0,1,1,1);
    add(0,0,0, 0,0,1,1,1); add(0,0,0, 0,0,1,1,1); add(0,0,0, 0,0,1,1,1); add(0,0,0, 0,0,1,1,1);
    add(0,0,0, 0,1,0,1,2); add(0,0,0, 0,0,0,1,2);
    // cfg_half=2 during HIGH; a second offer while not ready must be ignored.
    add(1,0,0, 1,0,1,1,2); add(1,1,2, 1,0,1,0,2); add(1,0,0, 1,0,1,0,2); add(1,1,7, 1,0,1,0,2);
    add(1,0,0, 0,0,1,0,2); add(1,0,0, 0,0,1,0,2); add(1,0,0, 0,0,1,0,2); add(1,0,0, 0,0,1,0,2);
    add(1,0,0, 1,1,1,1,3); add(1,0,0, 1,0,1,1,3); add(1,0,0, 0,0,1,1,3); add(1,0,0, 0,0,1,1,3);
    add(0,0,0, 0,1,0,1,4); add(0,0,0, 0,0,0,1,4);
    // cfg_half=0 -> H=1; offer of 3 on an apply edge waits for a later boundary.
    add(0,1,0, 0,0,0,0,4); add(1,0,0, 1,0,1,1,4); add(1,0,0, 0,0,1,1,4); add(1,1,3, 1,1,1,0,5);
    add(1,0,0, 0,0,1,0,5); add(0,0,0, 0,1,0,0,6); add(0,0,0, 0,0,0,0,6);

    // Reset state, with enable held high to show reset dominates.
    step(); step();
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    enable = 1'b0;
    rst_n  = 1'b1;
    step(); step();
    check_all("idle_after_reset", 1'b0, 1'b0, 1'b0, 1'b1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      enable    = tbl[i].en;
      cfg_valid = tbl[i].cv;
      cfg_half  = tbl[i].ch;
      step();
      $display("vec %0d en=%0b cv=%0b ch=%0d -> sig=%0b tick=%0b busy=%0b rdy=%0b cnt=%0d",
               i, tbl[i].en, tbl[i].cv, tbl[i].ch, signalOut, period_tick, busy,
               cfg_ready, period_count);
      check_all($sformatf("vec%0d", i), tbl[i].sig, tbl[i].tick, tbl[i].bsy,
                tbl[i].rdy, int'(tbl[i].cnt));
    end
    cfg_valid = 1'b0;

    // 16 continuous periods at H=3 (pending value applied at start); count wraps 15 -> 0 -> 6.
    ticks = 0;
    for (int k = 0; k <= 96; k++) begin
      enable = (k < 96);
      step();
      if (period_tick) ticks++;
      check($sformatf("wrap%0d.signalOut", k), int'(signalOut), int'((k < 96) && ((k % 6) < 3)));
      check($sformatf("wrap%0d.period_tick", k), int'(period_tick), int'((k > 0) && ((k % 6) == 0)));
      check($sformatf("wrap%0d.period_count", k), int'(period_count), (6 + k / 6) % 16);
      check($sformatf("wrap%0d.busy", k), int'(busy), int'(k < 96));
      if ((k % 6) == 0)
        $display("wrap edge %0d sig=%0b tick=%0b count=%0d", k, signalOut, period_tick, period_count);
    end
    check("wrap.tick_total", ticks, 16);
    check("wrap.cfg_ready", int'(cfg_ready), 1);

    // Reset during the third HIGH cycle aborts the period immediately.
    enable = 1'b1;
    step(); step(); step();
    check("pre_rst.signalOut", int'(signalOut), 1);
    #3 rst_n = 1'b0;
    #1;
    $display("mid-period reset sig=%0b count=%0d busy=%0b", signalOut, period_count, busy);
    check_all("mid_rst", 1'b0, 1'b0, 1'b0, 1'b1, 0);
    for (int j = 0; j < 3; j++) begin
      step();
      check_all($sformatf("rst_hold%0d", j), 1'b0, 1'b0, 1'b0, 1'b1, 0);
    end
    enable = 1'b0;
    rst_n  = 1'b1;
    step();
    check_all("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b1, 0);

    // Half-period returns to the reset default of 4.
    enable = 1'b1;
    for (int j = 0; j <= 8; j++) begin
      step();
      check($sformatf("dflt%0d.signalOut", j), int'(signalOut), int'((j < 4) || (j == 8)));
      check($sformatf("dflt%0d.period_tick", j), int'(period_tick), int'(j == 8));
      check($sformatf("dflt%0d.period_count", j), int'(period_count), (j == 8) ? 1 : 0);
    end
    $display("default-half period done count=%0d", period_count);
    enable = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_generator.md
TICK_GENERATOR -- requirements
Module: tick_generator

Interface
REQ-001 Parameter HALF_W, default 17: width of the half-period count.
REQ-002 Parameter HALF_DEFAULT, default 50000: reset half-period in clk cycles (100 MHz to 1 kHz).
REQ-003 Parameter CNT_W, default 16: width of the completed-period counter.
REQ-004 clk  input  1: 100 MHz system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1: asynchronous, active-low reset.
REQ-006 enable  input  1: level request to run the square wave.
REQ-007 cfg_valid  input  1: new half-period offered on cfg_half.
REQ-008 cfg_half  input  HALF_W: requested half-period in clk cycles.
REQ-009 cfg_ready  output  1: block can accept cfg_half.
REQ-010 signalOut  output  1: registered square wave, 50% duty.
REQ-011 period_tick  output  1: one-cycle strobe marking the end of each full period.
REQ-012 busy  output  1: high in any state other than IDLE.
REQ-013 period_count  output  CNT_W: number of completed periods since reset.

Function
REQ-014 The block SHALL implement states IDLE, HIGH and LOW, with a down-counter cnt of HALF_W bits.
REQ-015 Active half-period register act_half SHALL set the length of each phase; pending register pend_half SHALL hold the accepted value, with flag pend_v.
REQ-016 A config handshake SHALL occur when cfg_valid and cfg_ready are both high at a clk edge; that edge captures cfg_half into pend_half and sets pend_v.
REQ-017 cfg_ready SHALL equal not pend_v.
REQ-018 A cfg_half value of 0 SHALL be captured as 1.
REQ-019 pend_half SHALL be copied to act_half, and pend_v cleared, only at the IDLE-to-HIGH transition or the LOW-to-HIGH transition; a period in progress never changes length.
REQ-020 IDLE with enable high at edge k: state HIGH, signalOut=1, and cnt=H-1 after edge k, where H is act_half after any pending update.
REQ-021 HIGH: cnt decrements each cycle; when cnt=0, state LOW, signalOut=0, cnt=H-1.
REQ-022 signalOut SHALL be high for exactly H cycles and low for exactly H cycles per period.
REQ-023 LOW with cnt=0 at an edge:
- period_tick=1 for that following cycle.
- period_count increments modulo 2^CNT_W.
- If enable is high, the next state is HIGH (reload as REQ-020); otherwise the next state is IDLE.
REQ-024 enable deasserted mid-period SHALL NOT truncate the period; the current HIGH and LOW phases complete in full, so downstream edge detectors always see whole periods.
REQ-025 In IDLE, signalOut SHALL be 0 and cnt SHALL hold.
REQ-026 A handshake in the same cycle as an apply transition SHALL be captured into pend_half and applied at the next period boundary, not the current one.
REQ-027 busy SHALL be 1 in HIGH and LOW, and 0 in IDLE.
REQ-028 period_count SHALL wrap from 2^CNT_W-1 to 0 without any side effect.
REQ-029 All outputs SHALL be driven directly from registers or from a decode of state only.

Reset
REQ-030 While rst_n=0, the block SHALL hold: state IDLE, signalOut=0, period_tick=0, busy=0, period_count=0, cnt=0, act_half=HALF_DEFAULT, pend_v=0, cfg_ready=1.
REQ-031 Reset asserted mid-period SHALL abort the period immediately; no period_tick is produced and no count is taken.
REQ-032 After rst_n rises, the block SHALL start on the first edge with enable high.

Verification
REQ-033 The bench SHALL cover these scenarios (HALF_DEFAULT=4, CNT_W=4 unless stated):
- Reset release, then enable high at edge 0 -> signalOut high for edges 1-4, low for 5-8, period_tick at cycle 8, period_count=1.
- enable dropped at cycle 2 -> LOW phase still completes, single period_tick, busy falls after cycle 8, signalOut stays 0.
- cfg_half=2 accepted during HIGH of period 1 -> period 1 stays 4+4; period 2 is 2+2; cfg_ready low until the period-2 start.
- cfg_half=0 -> 1-cycle high and 1-cycle low phases; signalOut toggles every cycle.
- 16 continuous periods -> period_count wraps 15 to 0; period_tick pulses once per period.
- rst_n low at cycle 3 of HIGH -> signalOut=0 immediately, period_count=0, no period_tick.
